// File: rtl/shift_target_if.sv
// Bus bundle for shift_target: external shift/storage controls, parallel data and status flags.
interface shift_target_if #(
  parameter int WIDTH = 16
);
  logic             shcp;
  logic             stcp;
  logic             pl_n;
  logic             oe_n;
  logic             sdata_in;
  logic [WIDTH-1:0] pdata_in;
  logic             err_clr;
  logic             sdata_out;
  logic [WIDTH-1:0] pdata_out;
  logic             pdata_oe;
  logic             frame_done;
  logic             len_err;
  logic             sync_err;

  modport master (
    output shcp, stcp, pl_n, oe_n, sdata_in, pdata_in, err_clr,
    input  sdata_out, pdata_out, pdata_oe, frame_done, len_err, sync_err
  );

  modport slave (
    input  shcp, stcp, pl_n, oe_n, sdata_in, pdata_in, err_clr,
    output sdata_out, pdata_out, pdata_oe, frame_done, len_err, sync_err
  );
endinterface

// File: rtl/shift_target.sv
// Clk-domain shift/storage register driven by asynchronous 595-style controls,
// with frame-length and edge-collision error flags.
module shift_target #(
  parameter int                            SHIFT_TARGET_WIDTH = 16,
  parameter logic [SHIFT_TARGET_WIDTH-1:0] SHIFT_TARGET_INIT  = SHIFT_TARGET_WIDTH'(16'h8241)
) (
  input logic           clk,
  input logic           rst_n,
  shift_target_if.slave bus
);
  localparam int W = SHIFT_TARGET_WIDTH;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic shcp_p0_q, shcp_p1_q, shcp_p2_q;
  logic stcp_p0_q, stcp_p1_q, stcp_p2_q;
  logic pl_n_p0_q, pl_n_p1_q;
  logic oe_n_p0_q, oe_n_p1_q;
  logic sdi_p0_q, sdi_p1_q;

  logic [W-1:0] sreg_q, sreg_d;
  logic [W-1:0] pout_q, pout_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         sdo_q, oe_q, done_q, done_d;
  logic         len_q, len_d, sync_q, sync_d;

  logic shcp_rise, stcp_rise, shift_acc, store_acc, len_set, sync_set;

  // p1 -> p2: rise detection on synchronized clocks against history flop
  assign shcp_rise = shcp_p1_q & ~shcp_p2_q;
  assign stcp_rise = stcp_p1_q & ~stcp_p2_q;
  assign shift_acc = shcp_rise & ~stcp_rise;
  assign store_acc = stcp_rise & ~shcp_rise;
  assign sync_set  = (shcp_rise & stcp_rise) |
                     (shcp_p1_q & stcp_p1_q & ~shcp_rise & ~stcp_rise);

  always_comb begin
    sreg_d  = sreg_q;
    pout_d  = pout_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    len_set = 1'b0;
    if (shift_acc) begin
      sreg_d = {sreg_q[W-2:0], sdi_p1_q};
      cnt_d  = sat_inc8(cnt_q);
    end
    if (store_acc) begin
      // Storage captures the pre-load shift contents.
      pout_d  = sreg_q;
      cnt_d   = 8'd0;
      done_d  = 1'b1;
      len_set = (cnt_q != 8'd0) && ({24'd0, cnt_q} != 32'(W));
      if (!pl_n_p1_q) sreg_d = bus.pdata_in;
    end
    len_d  = len_set  | (len_q  & ~bus.err_clr);
    sync_d = sync_set | (sync_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shcp_p0_q <= 1'b0; shcp_p1_q <= 1'b0; shcp_p2_q <= 1'b0;
      stcp_p0_q <= 1'b0; stcp_p1_q <= 1'b0; stcp_p2_q <= 1'b0;
      pl_n_p0_q <= 1'b1; pl_n_p1_q <= 1'b1;
      oe_n_p0_q <= 1'b1; oe_n_p1_q <= 1'b1;
      sdi_p0_q  <= 1'b0; sdi_p1_q  <= 1'b0;
      sreg_q    <= SHIFT_TARGET_INIT;
      pout_q    <= SHIFT_TARGET_INIT;
      sdo_q     <= SHIFT_TARGET_INIT[W-1];
      cnt_q     <= 8'd0;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
      len_q     <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      // p0 -> p1: two-flop synchronizers, then history for the clocks
      shcp_p0_q <= bus.shcp;     shcp_p1_q <= shcp_p0_q; shcp_p2_q <= shcp_p1_q;
      stcp_p0_q <= bus.stcp;     stcp_p1_q <= stcp_p0_q; stcp_p2_q <= stcp_p1_q;
      pl_n_p0_q <= bus.pl_n;     pl_n_p1_q <= pl_n_p0_q;
      oe_n_p0_q <= bus.oe_n;     oe_n_p1_q <= oe_n_p0_q;
      sdi_p0_q  <= bus.sdata_in; sdi_p1_q  <= sdi_p0_q;
      // p2: architectural state and registered outputs
      sreg_q    <= sreg_d;
      pout_q    <= pout_d;
      sdo_q     <= sreg_d[W-1];
      cnt_q     <= cnt_d;
      oe_q      <= ~oe_n_p1_q;
      done_q    <= done_d;
      len_q     <= len_d;
      sync_q    <= sync_d;
    end
  end

  assign bus.sdata_out  = sdo_q;
  assign bus.pdata_out  = pout_q;
  assign bus.pdata_oe   = oe_q;
  assign bus.frame_done = done_q;
  assign bus.len_err    = len_q;
  assign bus.sync_err   = sync_q;
endmodule

// File: tb/tb_shift_target.sv
// Self-checking bench for shift_target: directed scenarios plus randomized frames
// compared against a pulse-level behavioural model.
module tb_shift_target;
  localparam logic [15:0] INIT = 16'h8241;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  // Reference model state, updated once per complete external pulse
  logic [15:0] m_sreg, m_pout;
  int          m_cnt;
  logic        m_len, m_sync;

  shift_target_if #(.WIDTH(16)) ifa ();
  shift_target_if #(.WIDTH(16)) ifb ();

  assign ifb.shcp     = ifa.shcp;
  assign ifb.stcp     = ifa.stcp;
  assign ifb.pl_n     = ifa.pl_n;
  assign ifb.oe_n     = ifa.oe_n;
  assign ifb.pdata_in = ifa.pdata_in;
  assign ifb.err_clr  = ifa.err_clr;
  assign ifb.sdata_in = ifa.sdata_out;

  shift_target #(.SHIFT_TARGET_WIDTH(16), .SHIFT_TARGET_INIT(16'h8241)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  shift_target #(.SHIFT_TARGET_WIDTH(16), .SHIFT_TARGET_INIT(16'h8241)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  always #5 clk = ~clk;

  always @(negedge clk) if (ifa.frame_done === 1'b1) done_cnt++;

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_sreg = INIT; m_pout = INIT; m_cnt = 0; m_len = 1'b0; m_sync = 1'b0;
  endtask

  task automatic shift_bit(input logic d);
    ifa.sdata_in = d; ifa.shcp = 1'b1; clks(4);
    ifa.shcp = 1'b0; clks(4);
    m_sreg = {m_sreg[14:0], d};
    m_cnt  = (m_cnt >= 255) ? 255 : m_cnt + 1;
  endtask

  task automatic store_pulse();
    ifa.stcp = 1'b1; clks(4);
    ifa.stcp = 1'b0; clks(4);
    m_pout = m_sreg;
    if (m_cnt != 0 && m_cnt != 16) m_len = 1'b1;
    if (ifa.pl_n == 1'b0) m_sreg = ifa.pdata_in;
    m_cnt = 0;
  endtask

  task automatic clear_err();
    ifa.err_clr = 1'b1; clks(1);
    ifa.err_clr = 1'b0; clks(1);
    m_len = 1'b0; m_sync = 1'b0;
  endtask

  task automatic test_reset();
    ifa.shcp = 0; ifa.stcp = 0; ifa.pl_n = 1; ifa.oe_n = 1; ifa.sdata_in = 0;
    ifa.pdata_in = '0; ifa.err_clr = 0;
    rst_n = 1'b0; model_reset();
    #50;
    checks++; if (ifa.pdata_out !== INIT) begin failures++; $display("FAIL rst_pout_during got=%h exp=%h", ifa.pdata_out, INIT); end
    checks++; if (ifa.sdata_out !== 1'b1) begin failures++; $display("FAIL rst_sdo_during got=%b exp=1", ifa.sdata_out); end
    #50 rst_n = 1'b1;
    clks(6);
    checks++; if (ifa.pdata_out !== INIT) begin failures++; $display("FAIL rst_pout got=%h exp=%h", ifa.pdata_out, INIT); end
    checks++; if (ifa.sdata_out !== 1'b1) begin failures++; $display("FAIL rst_sdo got=%b exp=1", ifa.sdata_out); end
    checks++; if ({ifa.len_err, ifa.sync_err, ifa.pdata_oe, ifa.frame_done} !== 4'b0000) begin failures++;
      $display("FAIL rst_flags got=%b exp=0000", {ifa.len_err, ifa.sync_err, ifa.pdata_oe, ifa.frame_done}); end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL rst_done got=%0d exp=0", done_cnt); end
  endtask

  task automatic test_frame();
    logic [15:0] word; int d0;
    word = 16'hA5C3; d0 = done_cnt;
    for (int i = 15; i >= 0; i--) shift_bit(word[i]);
    store_pulse();
    checks++; if (ifa.pdata_out !== 16'hA5C3) begin failures++; $display("FAIL frame_pout got=%h exp=a5c3", ifa.pdata_out); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL frame_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (ifa.len_err !== 1'b0) begin failures++; $display("FAIL frame_len got=%b exp=0", ifa.len_err); end
  endtask

  task automatic test_load();
    ifa.pdata_in = 16'h3C96; ifa.pl_n = 1'b0;
    store_pulse();
    ifa.pl_n = 1'b1;
    checks++; if (ifa.sdata_out !== 1'b0) begin failures++; $display("FAIL load_sdo got=%b exp=0", ifa.sdata_out); end
    checks++; if (ifa.pdata_out !== m_pout) begin failures++; $display("FAIL load_pout got=%h exp=%h", ifa.pdata_out, m_pout); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (ifa.sdata_out !== m_sreg[15]) begin failures++;
        $display("FAIL load_bit%0d got=%b exp=%b", i, ifa.sdata_out, m_sreg[15]); end
      shift_bit(1'b0);
    end
    checks++; if (ifa.len_err !== 1'b0) begin failures++; $display("FAIL load_len got=%b exp=0", ifa.len_err); end
  endtask

  task automatic test_short_frame();
    for (int i = 0; i < 15; i++) shift_bit(1'($urandom_range(0, 1)));
    store_pulse();
    checks++; if (ifa.len_err !== 1'b1) begin failures++; $display("FAIL short_len got=%b exp=1", ifa.len_err); end
    checks++; if (ifa.pdata_out !== m_pout) begin failures++; $display("FAIL short_pout got=%h exp=%h", ifa.pdata_out, m_pout); end
    clear_err();
    checks++; if (ifa.len_err !== 1'b0) begin failures++; $display("FAIL short_clr got=%b exp=0", ifa.len_err); end
  endtask

  task automatic test_simultaneous();
    int d0; d0 = done_cnt;
    shift_bit(1'b1); shift_bit(1'b0);
    ifa.err_clr = 1'b1;
    ifa.sdata_in = 1'b1; ifa.shcp = 1'b1; ifa.stcp = 1'b1; clks(4);
    checks++; if (ifa.sync_err !== 1'b1) begin failures++; $display("FAIL simul_prio got=%b exp=1", ifa.sync_err); end
    ifa.shcp = 1'b0; ifa.stcp = 1'b0; clks(4);
    checks++; if (ifa.sync_err !== 1'b0) begin failures++; $display("FAIL simul_clrhold got=%b exp=0", ifa.sync_err); end
    ifa.err_clr = 1'b0; clks(1);
    ifa.shcp = 1'b1; ifa.stcp = 1'b1; clks(4);
    ifa.shcp = 1'b0; ifa.stcp = 1'b0; clks(4);
    m_sync = 1'b1;
    checks++; if (ifa.sync_err !== 1'b1) begin failures++; $display("FAIL simul_sync got=%b exp=1", ifa.sync_err); end
    checks++; if (ifa.pdata_out !== m_pout) begin failures++; $display("FAIL simul_pout got=%h exp=%h", ifa.pdata_out, m_pout); end
    checks++; if (done_cnt !== d0) begin failures++; $display("FAIL simul_done got=%0d exp=%0d", done_cnt, d0); end
    checks++; if (ifa.sdata_out !== m_sreg[15]) begin failures++; $display("FAIL simul_sreg got=%b exp=%b", ifa.sdata_out, m_sreg[15]); end
    // Two shifts remain counted: a store now must report a length error.
    store_pulse();
    checks++; if (ifa.len_err !== m_len) begin failures++; $display("FAIL simul_cnt got=%b exp=%b", ifa.len_err, m_len); end
    clear_err();
  endtask

  task automatic test_overlap();
    int d0; d0 = done_cnt;
    ifa.sdata_in = 1'b1; ifa.shcp = 1'b1; clks(4);
    ifa.stcp = 1'b1; clks(4);
    ifa.shcp = 1'b0; clks(4);
    ifa.stcp = 1'b0; clks(4);
    m_sreg = {m_sreg[14:0], 1'b1}; m_cnt = 1;
    m_pout = m_sreg; m_len = 1'b1; m_cnt = 0; m_sync = 1'b1;
    checks++; if (ifa.sync_err !== 1'b1) begin failures++; $display("FAIL ovl_sync got=%b exp=1", ifa.sync_err); end
    checks++; if (ifa.pdata_out !== m_pout) begin failures++; $display("FAIL ovl_pout got=%h exp=%h", ifa.pdata_out, m_pout); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL ovl_done got=%0d exp=1", done_cnt - d0); end
    clear_err();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 272; i++) shift_bit(1'($urandom_range(0, 1)));
    store_pulse();
    checks++; if (ifa.len_err !== 1'b1) begin failures++; $display("FAIL sat_len got=%b exp=1", ifa.len_err); end
    checks++; if (ifa.pdata_out !== m_pout) begin failures++; $display("FAIL sat_pout got=%h exp=%h", ifa.pdata_out, m_pout); end
    clear_err();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    rst_n = 1'b0; #23; rst_n = 1'b1; model_reset(); clks(4);
    checks++; if (ifa.pdata_out !== INIT) begin failures++; $display("FAIL mrst_pout got=%h exp=%h", ifa.pdata_out, INIT); end
    for (int i = 0; i < 16; i++) shift_bit(1'($urandom_range(0, 1)));
    store_pulse();
    checks++; if (ifa.len_err !== 1'b0) begin failures++; $display("FAIL mrst_len16 got=%b exp=0", ifa.len_err); end
    checks++; if (ifa.pdata_out !== m_pout) begin failures++; $display("FAIL mrst_pout2 got=%h exp=%h", ifa.pdata_out, m_pout); end
    for (int i = 0; i < 3; i++) shift_bit(1'b0);
    store_pulse();
    checks++; if (ifa.len_err !== 1'b1) begin failures++; $display("FAIL mrst_len3 got=%b exp=1", ifa.len_err); end
    clear_err();
  endtask

  task automatic test_random_frames();
    int n, d0;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(0, 18); d0 = done_cnt;
      ifa.oe_n = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) shift_bit(1'($urandom_range(0, 1)));
      ifa.pdata_in = 16'($urandom); ifa.pl_n = 1'($urandom_range(0, 1));
      store_pulse();
      ifa.pl_n = 1'b1;
      checks++; if (ifa.pdata_out !== m_pout) begin failures++; $display("FAIL rnd%0d_pout got=%h exp=%h", f, ifa.pdata_out, m_pout); end
      checks++; if (ifa.sdata_out !== m_sreg[15]) begin failures++; $display("FAIL rnd%0d_sdo got=%b exp=%b", f, ifa.sdata_out, m_sreg[15]); end
      checks++; if (ifa.len_err !== m_len) begin failures++; $display("FAIL rnd%0d_len got=%b exp=%b n=%0d", f, ifa.len_err, m_len, n); end
      checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL rnd%0d_done got=%0d exp=1", f, done_cnt - d0); end
      checks++; if (ifa.pdata_oe !== ~ifa.oe_n) begin failures++; $display("FAIL rnd%0d_oe got=%b exp=%b", f, ifa.pdata_oe, ~ifa.oe_n); end
      checks++; if (ifa.sync_err !== 1'b0) begin failures++; $display("FAIL rnd%0d_sync got=%b exp=0", f, ifa.sync_err); end
      clear_err();
    end
    ifa.oe_n = 1'b1;
  endtask

  task automatic test_chain();
    logic [31:0] word;
    word = 32'hDEADBEEF;
    for (int i = 31; i >= 0; i--) shift_bit(word[i]);
    store_pulse();
    checks++; if (ifa.pdata_out !== 16'hBEEF) begin failures++; $display("FAIL chain_up got=%h exp=beef", ifa.pdata_out); end
    checks++; if (ifb.pdata_out !== 16'hDEAD) begin failures++; $display("FAIL chain_down got=%h exp=dead", ifb.pdata_out); end
    clear_err();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_load();
    test_short_frame();
    test_simultaneous();
    test_overlap();
    test_saturation();
    test_mid_reset();
    test_random_frames();
    test_chain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
